cam_download_streamer: RTL and testbench

//  Per-camera capture store and download port, between a camera's fill-percent counter and the microcontroller PIO.
//  - While the camera films, captures synthetic frame bytes into a local RAM.
//  - While the buffer drains, streams the stored bytes to the microcontroller, one byte per 4-phase strobe/ack handshake.
//  - One instance per camera; feeds the curbyte/instrobe/load PIO ports.

---
 rtl/cam_download_streamer.sv | 195 +++++++++++++++++++
 tb/tb_cam_download_streamer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_download_streamer.sv
// Per-camera capture store: fills a small RAM with LFSR frame bytes while filming,
// then streams the stored bytes to the microcontroller over a 4-phase strobe/ack handshake.
module cam_download_streamer #(
    parameter int unsigned BYTES_PER_STEP = 4,
    parameter int unsigned MAX_PCT        = 10,
    parameter int unsigned PTR_W          = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       percent,
    input  logic             empty_buffer,
    input  logic             ack,
    output logic [7:0]       cur_byte,
    output logic             strobe,
    output logic             done,
    output logic             overflow,
    output logic [PTR_W-1:0] level
);

    localparam int unsigned DEPTH   = MAX_PCT * BYTES_PER_STEP;
    localparam int unsigned BURST_W = $clog2(BYTES_PER_STEP + 1);
    localparam int unsigned PCT_W   = 4;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_PRESENT,
        S_WAIT_ACK_LO,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    level_q, level_d;
    logic [BYTE_W-1:0]   lfsr_q, lfsr_d;
    logic [PCT_W-1:0]    last_pct_q, last_pct_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [BYTE_W-1:0]   cur_byte_q, cur_byte_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic                ack_meta_q, ack_s_q;

    logic [BYTE_W-1:0]   mem [DEPTH];
    logic                we_c;
    logic                full_c;
    logic [BYTE_W-1:0]   lfsr_next_c;

    assign full_c      = (wr_ptr_q >= PTR_W'(DEPTH));
    assign lfsr_next_c = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Two-flop synchronizer for the asynchronous microcontroller ack
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Capture RAM; contents survive reset
    always_ff @(posedge clock) begin
        if (we_c) begin
            mem[wr_ptr_q] <= lfsr_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lfsr_d     = lfsr_q;
        last_pct_d = last_pct_q;
        burst_d    = burst_q;
        cur_byte_d = cur_byte_q;
        strobe_d   = strobe_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        we_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                strobe_d = 1'b0;
                if (!empty_buffer) begin
                    if (percent == '0) begin
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        last_pct_d = '0;
                    end else if (percent > last_pct_q) begin
                        // A multi-step jump still yields a single burst
                        last_pct_d = percent;
                        burst_d    = BURST_W'(BYTES_PER_STEP);
                        state_d    = S_CAPTURE;
                    end
                end else if (level_q != '0) begin
                    cur_byte_d = mem[rd_ptr_q];
                    state_d    = S_PRESENT;
                end
            end

            S_CAPTURE: begin
                if (full_c) begin
                    overflow_d = 1'b1;
                end else begin
                    we_c     = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    lfsr_d   = lfsr_next_c;
                end
                burst_d = burst_q - BURST_W'(1);
                if (burst_q == BURST_W'(1)) begin
                    state_d = S_IDLE;
                end
            end

            S_PRESENT: begin
                if (!empty_buffer) begin
                    strobe_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (ack_s_q) begin
                    strobe_d = 1'b0;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    state_d  = S_WAIT_ACK_LO;
                end else begin
                    strobe_d = 1'b1;
                end
            end

            S_WAIT_ACK_LO: begin
                if (!empty_buffer) begin
                    strobe_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (!ack_s_q) begin
                    if (rd_ptr_q == wr_ptr_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cur_byte_d = mem[rd_ptr_q];
                        state_d    = S_PRESENT;
                    end
                end
            end

            S_DONE: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        level_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            lfsr_q     <= BYTE_W'(8'h01);
            last_pct_q <= '0;
            burst_q    <= '0;
            cur_byte_q <= '0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            lfsr_q     <= lfsr_d;
            last_pct_q <= last_pct_d;
            burst_q    <= burst_d;
            cur_byte_q <= cur_byte_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign cur_byte = cur_byte_q;
    assign strobe   = strobe_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign level    = level_q;

endmodule

// File: tb/tb_cam_download_streamer.sv
// Directed bench for cam_download_streamer: fill/flush via a vector table, drains,
// abort/resume and async reset via hand-written sequences.
module tb_cam_download_streamer;

    logic       clock;
    logic       reset_n;
    logic [3:0] percent;
    logic       empty_buffer;
    logic       ack;
    logic [7:0] cur_byte;
    logic       strobe;
    logic       done;
    logic       overflow;
    logic [5:0] level;

    int ncmp = 0;
    int nerr = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;
    int seq_idx = 0;
    logic [7:0] exp_seq [64];

    typedef struct {
        logic [3:0] pct;
        logic       eb;
        int         cycles;
        int         exp_level;
        logic       exp_strobe;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [22];

    cam_download_streamer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .percent      (percent),
        .empty_buffer (empty_buffer),
        .ack          (ack),
        .cur_byte     (cur_byte),
        .strobe       (strobe),
        .done         (done),
        .overflow     (overflow),
        .level        (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_strobe(input logic v);
        int t;
        t = 0;
        while (strobe !== v && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (strobe !== v) begin
            ncmp++;
            nerr++;
            $display("FAIL wait_strobe: strobe=%b expected %b after %0d cycles", strobe, v, t);
        end
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            percent      = vecs[i].pct;
            empty_buffer = vecs[i].eb;
            repeat (vecs[i].cycles) @(negedge clock);
            chk($sformatf("row%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            chk($sformatf("row%0d_strobe", i), 32'(strobe), 32'(vecs[i].exp_strobe));
            chk($sformatf("row%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end
    endtask

    // Full 4-phase handshake per byte, ack raised 3 cycles after strobe
    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            wait_strobe(1'b1);
            chk("drain_byte", 32'(cur_byte), 32'(exp_seq[seq_idx]));
            repeat (3) @(negedge clock);
            chk("byte_stable", 32'(cur_byte), 32'(exp_seq[seq_idx]));
            seq_idx++;
            ack = 1'b1;
            wait_strobe(1'b0);
            ack = 1'b0;
        end
    endtask

    initial begin
        int d0;
        int s0;

        exp_seq[0] = 8'h01;
        for (int i = 1; i < 64; i++) begin
            logic [7:0] p;
            p = exp_seq[i-1];
            exp_seq[i] = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
        end

        vecs[0]  = '{4'd0,  1'b0, 3, 0,  1'b0, 1'b0};
        vecs[1]  = '{4'd1,  1'b0, 6, 4,  1'b0, 1'b0};
        vecs[2]  = '{4'd2,  1'b0, 6, 8,  1'b0, 1'b0};
        vecs[3]  = '{4'd0,  1'b0, 3, 0,  1'b0, 1'b0};
        for (int p = 1; p <= 10; p++)
            vecs[3+p] = '{4'(p), 1'b0, 6, 4*p, 1'b0, 1'b0};
        vecs[14] = '{4'd11, 1'b0, 6, 40, 1'b0, 1'b1};
        vecs[15] = '{4'd0,  1'b0, 3, 0,  1'b0, 1'b1};
        vecs[16] = '{4'd1,  1'b0, 6, 4,  1'b0, 1'b1};
        vecs[17] = '{4'd2,  1'b0, 6, 8,  1'b0, 1'b1};
        vecs[18] = '{4'd3,  1'b0, 6, 4,  1'b0, 1'b1};
        vecs[19] = '{4'd0,  1'b0, 3, 0,  1'b0, 1'b1};
        vecs[20] = '{4'd1,  1'b0, 6, 4,  1'b0, 1'b1};
        vecs[21] = '{4'd1,  1'b0, 6, 4,  1'b0, 1'b0};

        reset_n = 1'b0;
        percent = 4'd0;
        empty_buffer = 1'b0;
        ack = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_cur_byte", 32'(cur_byte), 32'h0);
        chk("rst_strobe", 32'(strobe), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // Capture 0 -> 1 -> 2, then drain 8 bytes in write order
        apply_rows(0, 2);
        d0 = done_cnt;
        empty_buffer = 1'b1;
        drain(8);
        repeat (8) @(negedge clock);
        chk("drain8_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("drain8_level", 32'(level), 32'd0);
        empty_buffer = 1'b0;

        // Fill to 40, overflow on an extra burst, drain all 40
        apply_rows(3, 14);
        d0 = done_cnt;
        empty_buffer = 1'b1;
        drain(40);
        repeat (8) @(negedge clock);
        chk("drain40_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("drain40_level", 32'(level), 32'd0);
        empty_buffer = 1'b0;

        // Abort after 3 of 8 bytes; resume must show byte 4 once (LFSR frozen during overflow)
        apply_rows(15, 17);
        empty_buffer = 1'b1;
        drain(3);
        wait_strobe(1'b1);
        chk("abort_pre_byte", 32'(cur_byte), 32'(exp_seq[seq_idx]));
        empty_buffer = 1'b0;
        @(negedge clock);
        chk("abort_strobe", 32'(strobe), 32'h0);
        chk("abort_level", 32'(level), 32'd5);
        repeat (2) @(negedge clock);
        d0 = done_cnt;
        empty_buffer = 1'b1;
        drain(5);
        repeat (8) @(negedge clock);
        chk("resume_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("resume_level", 32'(level), 32'd0);
        empty_buffer = 1'b0;

        // Flush by percent 0, then empty drain produces nothing
        apply_rows(18, 19);
        d0 = done_cnt;
        s0 = strobe_cnt;
        empty_buffer = 1'b1;
        repeat (20) @(negedge clock);
        chk("empty_drain_strobes", 32'(strobe_cnt - s0), 32'd0);
        chk("empty_drain_done", 32'(done_cnt - d0), 32'd0);
        chk("empty_drain_level", 32'(level), 32'd0);
        empty_buffer = 1'b0;

        // Async reset in the middle of a handshake
        apply_rows(20, 20);
        empty_buffer = 1'b1;
        wait_strobe(1'b1);
        ack = 1'b1;
        @(negedge clock);
        chk("pre_reset_strobe", 32'(strobe), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_strobe", 32'(strobe), 32'h0);
        chk("async_rst_done", 32'(done), 32'h0);
        chk("async_rst_level", 32'(level), 32'h0);
        chk("async_rst_overflow", 32'(overflow), 32'h0);
        @(negedge clock);
        ack = 1'b0;
        empty_buffer = 1'b0;
        percent = 4'd0;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        seq_idx = 0;
        apply_rows(21, 21);
        empty_buffer = 1'b1;
        drain(1);
        empty_buffer = 1'b0;
        repeat (4) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
